// File: rtl/cache_ctrl_pkg.sv
// Shared types for the write-back cache controller: FSM state encoding and tag-width helpers.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_REFILL_REQ,
    ST_REFILL_WAIT,
    ST_RESP
  } state_e;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INDEX_W = 2;
  localparam int TAG_W       = DEF_ADDR_W - DEF_INDEX_W;

  function automatic int tag_width(input int addr_w, input int index_w);
    return addr_w - index_w;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Direct-mapped line storage: one combinational read port, one write port; valid/dirty cleared by rst.
module cache_line_store #(
  parameter int DATA_W     = 32,
  parameter int INDEX_W    = 2,
  parameter int LINE_TAG_W = cache_ctrl_pkg::TAG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    rd_idx_i,
  output logic                  rd_valid_o,
  output logic                  rd_dirty_o,
  output logic [LINE_TAG_W-1:0] rd_tag_o,
  output logic [DATA_W-1:0]     rd_data_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_W-1:0]    wr_idx_i,
  input  logic                  wr_dirty_i,
  input  logic [LINE_TAG_W-1:0] wr_tag_i,
  input  logic [DATA_W-1:0]     wr_data_i
);
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      dirty_q;
  logic [LINE_TAG_W-1:0] tag_q  [LINES];
  logic [DATA_W-1:0]     data_q [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

  // Tag and data only matter once the line is valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/param_wb_cache_ctrl.sv
// Direct-mapped, one-word-line write-back cache controller between a CPU port and a memory port.
// Define CACHE_STATS_EN to build saturating hit/miss counters; otherwise both counts read 0.
module param_wb_cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);
  localparam int TW = tag_width(ADDR_W, INDEX_W);

  state_e              state_q, state_d;
  logic                live_q;
  logic                req_we_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_wdata_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rdata_ld;

  logic [INDEX_W-1:0]  req_idx;
  logic [TW-1:0]       req_tag;
  logic                st_valid, st_dirty;
  logic [TW-1:0]       st_tag;
  logic [DATA_W-1:0]   st_data;
  logic                wr_en, wr_dirty;
  logic [DATA_W-1:0]   wr_data;
  logic                hit, victim_dirty;

  assign req_idx      = req_addr_q[INDEX_W-1:0];
  assign req_tag      = req_addr_q[ADDR_W-1:INDEX_W];
  assign hit          = st_valid && (st_tag == req_tag);
  assign victim_dirty = st_valid && st_dirty;

  cache_line_store #(
    .DATA_W    (DATA_W),
    .INDEX_W   (INDEX_W),
    .LINE_TAG_W(TW)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .rd_idx_i  (req_idx),
    .rd_valid_o(st_valid),
    .rd_dirty_o(st_dirty),
    .rd_tag_o  (st_tag),
    .rd_data_o (st_data),
    .wr_en_i   (wr_en),
    .wr_idx_i  (req_idx),
    .wr_dirty_i(wr_dirty),
    .wr_tag_i  (req_tag),
    .wr_data_i (wr_data)
  );

  // live_q keeps the CPU port closed until the first full cycle after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_req_valid && cpu_req_ready) begin
      req_we_q    <= cpu_req_we;
      req_addr_q  <= cpu_req_addr;
      req_wdata_q <= cpu_req_wdata;
    end
    if (rdata_ld) rdata_q <= rdata_d;
  end

  always_comb begin
    state_d       = state_q;
    wr_en         = 1'b0;
    wr_dirty      = 1'b0;
    wr_data       = req_wdata_q;
    rdata_ld      = 1'b0;
    rdata_d       = rdata_q;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state_q)
      ST_IDLE: if (cpu_req_valid && cpu_req_ready) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (hit) begin
          state_d = ST_RESP;
          if (req_we_q) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
          end else begin
            rdata_ld = 1'b1;
            rdata_d  = st_data;
          end
        end else if (victim_dirty) begin
          state_d = ST_WRITEBACK;
        end else if (req_we_q) begin
          wr_en    = 1'b1;
          wr_dirty = 1'b1;
          state_d  = ST_RESP;
        end else begin
          state_d = ST_REFILL_REQ;
        end
      end
      ST_WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {st_tag, req_idx};
        mem_req_wdata = st_data;
        if (mem_req_ready) begin
          if (req_we_q) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
            state_d  = ST_RESP;
          end else begin
            state_d = ST_REFILL_REQ;
          end
        end
      end
      ST_REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = req_addr_q;
        if (mem_req_ready) state_d = ST_REFILL_WAIT;
      end
      ST_REFILL_WAIT: begin
        if (mem_rsp_valid) begin
          wr_en    = 1'b1;
          wr_data  = mem_rsp_rdata;
          rdata_ld = 1'b1;
          rdata_d  = mem_rsp_rdata;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cpu_req_ready = (state_q == ST_IDLE) && live_q;
  assign cpu_rsp_valid = (state_q == ST_RESP);
  assign cpu_rsp_rdata = (cpu_rsp_valid && !req_we_q) ? rdata_q : '0;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == ST_LOOKUP) begin
      if (hit && (hit_cnt_q != 16'hFFFF))    hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (!hit && (miss_cnt_q != 16'hFFFF))  miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_param_wb_cache_ctrl.sv
// Scoreboard bench for param_wb_cache_ctrl: reference cache model predicts CPU responses and memory traffic.
module tb_param_wb_cache_ctrl;

`ifdef CACHE_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  lat;
  } crsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic        cpu_req_we = 1'b0;
  logic [7:0]  cpu_req_addr = '0;
  logic [31:0] cpu_req_wdata = '0;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rsp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [7:0]  mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int stall_cfg = 0;
  int rsp_delay = 2;
  int junk_req = 0;
  int rd_hs = 0;

  logic [31:0] gmem [256];
  logic        mv [4];
  logic        mdirty [4];
  logic [5:0]  mt [4];
  logic [31:0] mdat [4];
  crsp_t       cq [$];
  logic [40:0] mq [$];

  param_wb_cache_ctrl #(.ADDR_W(8), .DATA_W(32), .INDEX_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req_valid(cpu_req_valid),
    .cpu_req_ready(cpu_req_ready),
    .cpu_req_we   (cpu_req_we),
    .cpu_req_addr (cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(cpu_rsp_valid),
    .cpu_rsp_rdata(cpu_rsp_rdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_we   (mem_req_we),
    .mem_req_addr (mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mv[i]     = 1'b0;
      mdirty[i] = 1'b0;
      mt[i]     = '0;
      mdat[i]   = '0;
    end
    cq.delete();
    mq.delete();
  endtask

  task automatic predict(input logic we, input logic [7:0] a, input logic [31:0] wd);
    logic [1:0] ix;
    logic [5:0] tg;
    crsp_t      r;
    ix = a[1:0];
    tg = a[7:2];
    r.rdata = '0;
    r.lat   = 4'd0;
    if (mv[ix] && mt[ix] == tg) begin
      r.lat = 4'd2;
      if (we) begin
        mdat[ix]   = wd;
        mdirty[ix] = 1'b1;
      end else begin
        r.rdata = mdat[ix];
      end
    end else begin
      if (mv[ix] && mdirty[ix]) mq.push_back({1'b1, mt[ix], ix, mdat[ix]});
      if (we) begin
        mdat[ix]   = wd;
        mdirty[ix] = 1'b1;
      end else begin
        mq.push_back({1'b0, a, 32'h0});
        mdat[ix]   = gmem[a];
        mdirty[ix] = 1'b0;
        r.rdata    = gmem[a];
      end
      mv[ix] = 1'b1;
      mt[ix] = tg;
    end
    cq.push_back(r);
  endtask

  task automatic cpu_issue(input logic we, input logic [7:0] a, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = a;
    cpu_req_wdata = wd;
    while (cpu_req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", 64'(n < 50), 64'(1));
    predict(we, a, wd);
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    cpu_req_valid = 1'b0;
  endtask

  task automatic cpu_wait();
    int n = 0;
    while (cq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rsp_pending", 64'(cq.size()), 64'(0));
    check("mem_pending", 64'(mq.size()), 64'(0));
  endtask

  task automatic cpu_op(input logic we, input logic [7:0] a, input logic [31:0] wd);
    cpu_issue(we, a, wd);
    cpu_wait();
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_rdy"},   64'(cpu_req_ready), 64'(0));
    check({tag, "_rspv"},  64'(cpu_rsp_valid), 64'(0));
    check({tag, "_rspd"},  64'(cpu_rsp_rdata), 64'(0));
    check({tag, "_memv"},  64'(mem_req_valid), 64'(0));
    check({tag, "_mem"},   64'({mem_req_we, mem_req_addr, mem_req_wdata}), 64'(0));
    check({tag, "_cnt"},   64'({hit_count, miss_count}), 64'(0));
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outs_zero(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_rdy_after"}, 64'(cpu_req_ready), 64'(1));
  endtask

  // Memory model: optional ready stall, read responses after rsp_delay cycles.
  initial begin
    logic [40:0] snap;
    logic [40:0] cur;
    int          stall_left;
    bit          in_req;
    int          rcnt;
    logic [31:0] rdat;
    int          junk_done;
    stall_left = 0;
    in_req     = 1'b0;
    rcnt       = 0;
    rdat       = '0;
    junk_done  = 0;
    snap       = '0;
    for (int i = 0; i < 256; i++) gmem[i] = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC3};
    gmem[8'h05] = 32'h11223344;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      if (rst) begin
        in_req        = 1'b0;
        rcnt          = 0;
        mem_req_ready = 1'b0;
      end else begin
        if (junk_req != junk_done) begin
          junk_done     = junk_req;
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = 32'hFFFF_FFFF;
        end
        if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rdat;
          end
        end
        cur = {mem_req_we, mem_req_addr, mem_req_wdata};
        if (mem_req_valid) begin
          if (!in_req) begin
            in_req     = 1'b1;
            stall_left = stall_cfg;
            snap       = cur;
          end else begin
            check("mreq_stable", 64'(cur), 64'(snap));
            check("cpu_rdy_stall", 64'(cpu_req_ready), 64'(0));
          end
          if (stall_left > 0) begin
            stall_left--;
            mem_req_ready = 1'b0;
          end else begin
            mem_req_ready = 1'b1;
            in_req        = 1'b0;
            if (mq.size() == 0) check("mem_unexpected", 64'(1), 64'(0));
            else check("mreq", 64'(cur), 64'(mq.pop_front()));
            if (mem_req_we) begin
              gmem[mem_req_addr] = mem_req_wdata;
            end else begin
              rcnt = rsp_delay;
              rdat = gmem[mem_req_addr];
              rd_hs++;
            end
          end
        end else begin
          mem_req_ready = 1'b0;
        end
      end
    end
  end

  // CPU response monitor: pops the scoreboard on every response pulse.
  initial forever begin
    crsp_t e;
    @(negedge clk);
    if (!rst && cpu_rsp_valid) begin
      if (cq.size() == 0) begin
        check("rsp_unexpected", 64'(1), 64'(0));
      end else begin
        e = cq.pop_front();
        check("rsp_rdata", 64'(cpu_rsp_rdata), 64'(e.rdata));
        if (e.lat != 4'd0) check("rsp_latency", 64'(cyc - acc_cyc + 1), 64'(e.lat));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hs0;
    model_reset();
    #1 rst = 1'b1;
    #2 check_outs_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_reset", 64'(cpu_req_ready), 64'(1));

    // Read miss with refill, then hit on the same address.
    cpu_op(1'b0, 8'h05, '0);
    cpu_op(1'b0, 8'h05, '0);

    // Write miss installs dirty; conflicting read forces writeback under a stalled memory.
    cpu_op(1'b1, 8'h09, 32'hCAFE_BABE);
    stall_cfg = 5;
    cpu_op(1'b0, 8'h0D, '0);
    stall_cfg = 0;
    cpu_op(1'b0, 8'h09, '0);

    // Stray memory response while idle must be ignored.
    @(negedge clk);
    junk_req++;
    repeat (2) @(negedge clk);
    check("junk_rdy", 64'(cpu_req_ready), 64'(1));
    check("junk_rspv", 64'(cpu_rsp_valid), 64'(0));
    check("junk_memv", 64'(mem_req_valid), 64'(0));
    cpu_op(1'b0, 8'h09, '0);

    // Write miss over a dirty victim, then read miss over a dirty victim.
    cpu_op(1'b1, 8'h02, 32'h1234_5678);
    cpu_op(1'b1, 8'h06, 32'hA5A5_0606);
    cpu_op(1'b0, 8'h02, '0);
    cpu_op(1'b0, 8'h06, '0);

    // Reset while waiting for a refill.
    rsp_delay = 40;
    hs0 = rd_hs;
    cpu_issue(1'b0, 8'h21, '0);
    n = 0;
    while (rd_hs == hs0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("refill_hs", 64'(rd_hs - hs0), 64'(1));
    repeat (2) @(negedge clk);
    pulse_reset("midrst");
    rsp_delay = 2;
    cpu_op(1'b0, 8'h21, '0);
    cpu_op(1'b0, 8'h05, '0);

    // Statistics: 2 misses and 3 hits from a clean cache.
    pulse_reset("statrst");
    cpu_op(1'b0, 8'h05, '0);
    cpu_op(1'b0, 8'h05, '0);
    cpu_op(1'b1, 8'h05, 32'h0BAD_F00D);
    cpu_op(1'b0, 8'h06, '0);
    cpu_op(1'b0, 8'h06, '0);
    @(negedge clk);
    check("hit_count", 64'(hit_count), 64'(STATS_ON ? 16'd3 : 16'd0));
    check("miss_count", 64'(miss_count), 64'(STATS_ON ? 16'd2 : 16'd0));
    cpu_op(1'b0, 8'h05, '0);
    check("write_hit_data", 64'(mdat[1]), 64'(32'h0BAD_F00D));

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
